// File: rtl/ps_slicer_pkg.sv
// Shared definitions for the PacketStream slicer family: the slice-boundary
// rule, reused wherever a stream is cut into runtime-length slices.
package ps_slicer_pkg;

  // Operands arrive zero-extended to 32 bits so any counter width up to 32
  // can share this rule. The cur_len != 0 guard keeps cur_len - 1 from
  // wrapping when slicing is disabled.
  function automatic logic slice_brk(input logic [31:0] cnt,
                                     input logic [31:0] cur_len,
                                     input logic        eop);
    return eop | ((cur_len != 32'd0) && (cnt == cur_len - 32'd1));
  endfunction

endpackage

// File: rtl/ps_skid_buf.sv
// Generic 2-entry ready/valid register slice. The output and i_rdy both come
// straight from flops, so neither depends combinationally on o_rdy.
module ps_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             rst,
  input  logic             clk,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_val,
  output logic             i_rdy,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_val,
  input  logic             o_rdy
);

  logic [WIDTH-1:0] skid_dat;
  logic             skid_val;

  // The skid entry is the only overflow space, so the input is ready exactly
  // when that entry is empty.
  assign i_rdy = ~skid_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset as well as the valids so that
      // o_dat reads zero out of reset instead of an undefined value.
      o_val    <= 1'b0;
      o_dat    <= '0;
      skid_val <= 1'b0;
      skid_dat <= '0;
    end else if (!o_val || o_rdy) begin
      if (skid_val) begin
        o_dat    <= skid_dat;
        o_val    <= 1'b1;
        skid_val <= 1'b0;
      end else begin
        o_val <= i_val;
        if (i_val) o_dat <= i_dat;
      end
    end else if (i_val && !skid_val) begin
      // The output is stalled, so the accepted beat parks in the skid entry.
      skid_dat <= i_dat;
      skid_val <= 1'b1;
    end
  end

endmodule

// File: rtl/ps_dyn_slicer.sv
// PacketStream slicer with a per-packet runtime slice length. It inserts EOPs
// every len words and tags each word with start-of-slice and a slice index.
module ps_dyn_slicer
  import ps_slicer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LWIDTH = 8,
  parameter int IWIDTH = 4,
  parameter bit REGOUT = 1
) (
  input  logic              rst,
  input  logic              clk,
  input  logic [LWIDTH-1:0] len,
  input  logic [WIDTH-1:0]  i_dat,
  input  logic              i_val,
  input  logic              i_eop,
  output logic              i_rdy,
  output logic [WIDTH-1:0]  o_dat,
  output logic              o_val,
  output logic              o_sop,
  output logic              o_eop,
  output logic [IWIDTH-1:0] o_idx,
  input  logic              o_rdy
);

  typedef struct packed {
    logic [WIDTH-1:0]  dat;
    logic              sop;
    logic              eop;
    logic [IWIDTH-1:0] idx;
  } beat_t;

  logic              pkt_first;
  logic [LWIDTH-1:0] cnt;
  logic [LWIDTH-1:0] len_q;
  logic [LWIDTH-1:0] cur_len;
  logic [IWIDTH-1:0] idx;
  logic              acc;
  logic              brk;
  beat_t             beat;
  beat_t             out_beat;

  // len is only honoured on the first word; the rest of the packet uses the
  // value latched then.
  assign cur_len = pkt_first ? len : len_q;
  assign brk     = slice_brk(32'(cnt), 32'(cur_len), i_eop);
  assign acc     = i_val & i_rdy;
  assign beat    = '{dat: i_dat, sop: (cnt == '0), eop: brk, idx: idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_first <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      len_q     <= '0;
    end else if (acc) begin
      if (pkt_first) len_q <= len;
      pkt_first <= i_eop;
      // With slicing disabled the counter saturates so it never wraps to 0
      // and fakes a start-of-slice.
      if (brk)              cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + LWIDTH'(1);
      if (i_eop)            idx <= '0;
      else if (brk)         idx <= idx + IWIDTH'(1);
    end
  end

  generate
    if (REGOUT) begin : g_reg
      ps_skid_buf #(.WIDTH($bits(beat_t))) u_skid (
        .rst   (rst),
        .clk   (clk),
        .i_dat (beat),
        .i_val (i_val),
        .i_rdy (i_rdy),
        .o_dat (out_beat),
        .o_val (o_val),
        .o_rdy (o_rdy)
      );
    end else begin : g_comb
      assign out_beat = beat;
      assign o_val    = i_val;
      assign i_rdy    = o_rdy;
    end
  endgenerate

  assign o_dat = out_beat.dat;
  assign o_sop = out_beat.sop;
  assign o_eop = out_beat.eop;
  assign o_idx = out_beat.idx;

endmodule

// File: tb/tb_ps_dyn_slicer.sv
// Bench for ps_dyn_slicer: a combinational instance driven with directed
// packets, and a registered instance driven with random packets and stalls.
module tb_ps_dyn_slicer;

  localparam int BW = 8 + 1 + 1 + 4;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] len0, i_dat0, o_dat0;
  logic       i_val0, i_eop0, i_rdy0, o_val0, o_sop0, o_eop0, o_rdy0;
  logic [3:0] o_idx0;

  logic [7:0] len1, i_dat1, o_dat1;
  logic       i_val1, i_eop1, i_rdy1, o_val1, o_sop1, o_eop1, o_rdy1;
  logic [3:0] o_idx1;

  int tests = 0;
  int fails = 0;

  logic [BW-1:0] expq[$];
  int            pkt_n[$];
  int            pkt_l[$];
  logic [7:0]    pkt_dat[$];

  always #5 clk = ~clk;

  ps_dyn_slicer #(.WIDTH(8), .LWIDTH(8), .IWIDTH(4), .REGOUT(0)) dut0 (
    .rst(rst), .clk(clk), .len(len0), .i_dat(i_dat0), .i_val(i_val0),
    .i_eop(i_eop0), .i_rdy(i_rdy0), .o_dat(o_dat0), .o_val(o_val0),
    .o_sop(o_sop0), .o_eop(o_eop0), .o_idx(o_idx0), .o_rdy(o_rdy0)
  );

  ps_dyn_slicer #(.WIDTH(8), .LWIDTH(8), .IWIDTH(4), .REGOUT(1)) dut1 (
    .rst(rst), .clk(clk), .len(len1), .i_dat(i_dat1), .i_val(i_val1),
    .i_eop(i_eop1), .i_rdy(i_rdy1), .o_dat(o_dat1), .o_val(o_val1),
    .o_sop(o_sop1), .o_eop(o_eop1), .o_idx(o_idx1), .o_rdy(o_rdy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word k of an n-word packet sliced with length L: slice k/L, first word
  // when k is a multiple of L, last word at a multiple boundary or packet end.
  function automatic logic [BW-1:0] exp_beat(input int k, input int n, input int L,
                                             input logic [7:0] d);
    logic       sop, eop;
    logic [3:0] idx;
    sop = (L == 0) ? (k == 0) : (k % L == 0);
    eop = (k == n - 1) || (L != 0 && (k % L) == L - 1);
    idx = (L == 0) ? 4'd0 : 4'((k / L) % 16);
    return {d, sop, eop, idx};
  endfunction

  task automatic send0(input logic [7:0] d, input logic e, input logic [7:0] l,
                       input logic [BW-1:0] exp);
    @(negedge clk);
    i_dat0 = d; i_eop0 = e; i_val0 = 1'b1; len0 = l;
    #1;
    check("a_beat", {o_dat0, o_sop0, o_eop0, o_idx0}, exp);
    check("a_val_rdy", {o_val0, i_rdy0}, 2'b11);
    @(posedge clk);
  endtask

  task automatic run_pkt0(input int n, input int L, input int lmid);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      send0(d, k == n - 1, 8'((k == 0) ? L : lmid), exp_beat(k, n, L, d));
    end
  endtask

  task automatic add_pkt(input int n, input int L);
    logic [7:0] d;
    pkt_n.push_back(n);
    pkt_l.push_back(L);
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      pkt_dat.push_back(d);
      expq.push_back(exp_beat(k, n, L, d));
    end
  endtask

  // Holds one word on the registered instance until it is accepted.
  task automatic send1(input logic [7:0] d, input logic e, input logic [7:0] l);
    logic r;
    int   w;
    @(negedge clk);
    i_dat1 = d; i_eop1 = e; i_val1 = 1'b1; len1 = l;
    w = 0;
    forever begin
      r = i_rdy1;
      @(posedge clk);
      if (r) break;
      @(negedge clk);
      w++;
      if (w > 200) begin
        fails++;
        $display("FAIL b_input_stuck observed=i_rdy low for %0d cycles expected=accept", w);
        $fatal(1, "input never accepted");
      end
    end
  endtask

  task automatic drive_b();
    int wi = 0;
    for (int p = 0; p < pkt_n.size(); p++) begin
      for (int k = 0; k < pkt_n[p]; k++) begin
        send1(pkt_dat[wi], k == pkt_n[p] - 1,
              8'((k == 0) ? pkt_l[p] : $urandom_range(0, 255)));
        wi++;
      end
    end
    @(negedge clk);
    i_val1 = 1'b0;
  endtask

  task automatic mon_b(input int total);
    int            got = 0;
    int            cyc = 0;
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [BW-1:0] pb = '0;
    logic [BW-1:0] cur;
    while (got < total && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cur = {o_dat1, o_sop1, o_eop1, o_idx1};
      if (pv && pr) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL b_extra observed=%h expected=no beat", pb);
        end else begin
          check("b_beat", pb, expq.pop_front());
        end
        got++;
      end else if (pv) begin
        check("b_hold", {o_val1, cur}, {1'b1, pb});
      end
      pv = o_val1;
      pb = cur;
      o_rdy1 = 1'($urandom);
      pr = o_rdy1;
    end
    check("b_count", got, total);
    @(negedge clk);
    check("b_empty", o_val1, 1'b0);
    o_rdy1 = 1'b1;
  endtask

  task automatic play_b();
    int total;
    total = expq.size();
    fork
      drive_b();
      mon_b(total);
    join
    pkt_n.delete();
    pkt_l.delete();
    pkt_dat.delete();
    expq.delete();
  endtask

  initial begin
    rst = 1'b1;
    len0 = '0; i_dat0 = '0; i_val0 = 1'b0; i_eop0 = 1'b0; o_rdy0 = 1'b1;
    len1 = '0; i_dat1 = '0; i_val1 = 1'b0; i_eop1 = 1'b0; o_rdy1 = 1'b1;
    #2;
    check("rst_reg_out", {o_val1, o_sop1, o_eop1, o_idx1, o_dat1}, '0);
    check("rst_comb_out", {o_val0, i_rdy0}, 2'b01);
    @(negedge clk);
    rst = 1'b0;

    // Directed slicing on the combinational instance.
    run_pkt0(10, 4, 4);
    run_pkt0(8, 3, 5);
    run_pkt0(8, 5, 5);
    run_pkt0(7, 0, 0);
    run_pkt0(8, 4, 4);
    run_pkt0(3, 4, 4);
    run_pkt0(4, 1, 1);
    run_pkt0(6, 2, 7);
    @(negedge clk);
    i_val0 = 1'b0;

    // Registered instance: random packets and random output stalls.
    for (int p = 0; p < 14; p++)
      add_pkt($urandom_range(1, 9), (p < 5) ? 2 : $urandom_range(0, 4));
    play_b();

    // Reset in the middle of a len=4 packet, then a fresh len=3 packet.
    o_rdy1 = 1'b1;
    for (int k = 0; k < 3; k++) send1(8'($urandom), 1'b0, 8'd4);
    @(negedge clk);
    i_val1 = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_val", o_val1, 1'b0);
    check("mid_rst_beat", {o_dat1, o_sop1, o_eop1, o_idx1}, '0);
    @(negedge clk);
    rst = 1'b0;
    add_pkt(4, 3);
    play_b();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
